alu_exec_unit: RTL and testbench

- Executes the 5-bit ALU control codes produced by the ALU control decode stage; sits in the EX stage of the multicycle MIPS datapath.
- Single-cycle ops (arith/logic/shift/compare/branch) complete in 1 clock.
- imul and divi run iteratively (shift-add / restoring divide); the FSM sequences the main-control wait via start/busy/done.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_exec_unit_seq_muldiv.sv | 75 +++++++
 rtl/alu_exec_unit.sv | 198 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, EX-stage FSM encoding and helpers
package alu_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_NOT  = 5'd2;
    localparam logic [4:0] ALU_LSL  = 5'd3;
    localparam logic [4:0] ALU_LSR  = 5'd4;
    localparam logic [4:0] ALU_AND  = 5'd5;
    localparam logic [4:0] ALU_OR   = 5'd6;
    localparam logic [4:0] ALU_SLT  = 5'd7;
    localparam logic [4:0] ALU_BEQ  = 5'd8;
    localparam logic [4:0] ALU_BNE  = 5'd9;
    localparam logic [4:0] ALU_BGT  = 5'd10;
    localparam logic [4:0] ALU_BGE  = 5'd11;
    localparam logic [4:0] ALU_BLT  = 5'd12;
    localparam logic [4:0] ALU_BLE  = 5'd13;
    localparam logic [4:0] ALU_JUMP = 5'd14;
    localparam logic [4:0] ALU_IMUL = 5'd15;
    localparam logic [4:0] ALU_DIVI = 5'd16;
    localparam logic [4:0] ALU_SRA  = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } exec_state_t;

    function automatic logic is_multicycle(input logic [4:0] code);
        return (code == ALU_IMUL) || (code == ALU_DIVI);
    endfunction

endpackage

// File: rtl/alu_exec_unit_seq_muldiv.sv
// rtl/alu_exec_unit_seq_muldiv.sv - iterative unsigned shift-add multiply / restoring divide
module seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             is_div,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    input  logic             step,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             last
);

    localparam int CW = $clog2(WIDTH) + 1;

    // acc is the running product (multiply) or partial remainder (divide);
    // xr is the multiplier / dividend-becoming-quotient; yr the multiplicand / divisor.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic             div_mode;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   trial;

    always_comb begin
        r_sh  = {acc, xr[WIDTH-1]};
        trial = r_sh - {1'b0, yr};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            xr       <= '0;
            yr       <= '0;
            div_mode <= 1'b0;
            count    <= '0;
        end else if (load) begin
            acc      <= '0;
            xr       <= mag_a;
            yr       <= mag_b;
            div_mode <= is_div;
            count    <= '0;
        end else if (step) begin
            count <= count + CW'(1);
            if (div_mode) begin
                // Partial remainder always stays below the divisor, so a set
                // top bit of trial can only mean the subtraction went negative.
                if (!trial[WIDTH]) begin
                    acc <= trial[WIDTH-1:0];
                    xr  <= {xr[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= r_sh[WIDTH-1:0];
                    xr  <= {xr[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (xr[0]) begin
                    acc <= acc + yr;
                end
                xr <= xr >> 1;
                yr <= yr << 1;
            end
        end
    end

    assign prod_lo = acc;
    assign quot    = xr;
    assign rem     = acc;
    assign last    = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU: single-cycle ops plus iterative signed imul/divi
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       alu_cnt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rem_out,
    output logic             cond,
    output logic             zero,
    output logic             div0,
    output logic             illegal,
    output logic             busy,
    output logic             done
);

    exec_state_t state;
    exec_state_t state_next;

    logic             accept;
    logic             load;
    logic             step;
    logic             op_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             last;
    logic [WIDTH-1:0] fix_mag;
    logic [WIDTH-1:0] fix_result;
    logic [WIDTH-1:0] fix_rem;

    logic [WIDTH-1:0] sc_result;
    logic [WIDTH-1:0] sc_rem;
    logic             sc_cond;
    logic             sc_div0;
    logic             sc_illegal;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic             lt;
    logic             eq;

    assign mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .is_div  (alu_cnt == ALU_DIVI),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .step    (step),
        .prod_lo (prod_lo),
        .quot    (quot),
        .rem     (rem),
        .last    (last)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = start;
                // Divide by zero is resolved at accept time and never iterates.
                if (start && is_multicycle(alu_cnt) && !(alu_cnt == ALU_DIVI && b == '0)) begin
                    load       = 1'b1;
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                step = 1'b1;
                if (last) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        diff  = a - b;
        shamt = b[SHW-1:0];
        lt    = $signed(a) < $signed(b);
        eq    = (a == b);
    end

    always_comb begin
        sc_result  = '0;
        sc_rem     = '0;
        sc_cond    = 1'b0;
        sc_div0    = 1'b0;
        sc_illegal = 1'b0;
        case (alu_cnt)
            ALU_ADD:  sc_result = a + b;
            ALU_SUB:  sc_result = diff;
            ALU_NOT:  sc_result = ~a;
            ALU_LSL:  sc_result = a << shamt;
            ALU_LSR:  sc_result = a >> shamt;
            ALU_AND:  sc_result = a & b;
            ALU_OR:   sc_result = a | b;
            ALU_SLT:  sc_result = {{(WIDTH-1){1'b0}}, lt};
            ALU_BEQ:  begin sc_result = diff; sc_cond = eq;        end
            ALU_BNE:  begin sc_result = diff; sc_cond = !eq;       end
            ALU_BGT:  begin sc_result = diff; sc_cond = !lt && !eq; end
            ALU_BGE:  begin sc_result = diff; sc_cond = !lt;       end
            ALU_BLT:  begin sc_result = diff; sc_cond = lt;        end
            ALU_BLE:  begin sc_result = diff; sc_cond = lt || eq;  end
            ALU_JUMP: begin sc_result = b;    sc_cond = 1'b1;      end
            ALU_IMUL: begin end
            ALU_DIVI: begin
                sc_result = '1;
                sc_rem    = a;
                sc_div0   = 1'b1;
            end
            ALU_SRA:  sc_result = WIDTH'($signed(a) >>> shamt);
            default:  sc_illegal = 1'b1;
        endcase
    end

    // Quotient sign is sign(a)^sign(b); remainder follows the dividend.
    always_comb begin
        fix_mag    = op_div ? quot : prod_lo;
        fix_result = neg_q ? (~fix_mag + 1'b1) : fix_mag;
        fix_rem    = '0;
        if (op_div) begin
            fix_rem = neg_r ? (~rem + 1'b1) : rem;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result  <= '0;
            rem_out <= '0;
            cond    <= 1'b0;
            zero    <= 1'b0;
            div0    <= 1'b0;
            illegal <= 1'b0;
            done    <= 1'b0;
            op_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept && load) begin
                div0    <= 1'b0;
                illegal <= 1'b0;
                op_div  <= (alu_cnt == ALU_DIVI);
                neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
                neg_r   <= a[WIDTH-1];
            end else if (accept) begin
                done    <= 1'b1;
                result  <= sc_result;
                rem_out <= sc_rem;
                cond    <= sc_cond;
                zero    <= (sc_result == '0);
                div0    <= sc_div0;
                illegal <= sc_illegal;
            end
            if (state == ST_FIX) begin
                done    <= 1'b1;
                result  <= fix_result;
                rem_out <= fix_rem;
                cond    <= 1'b0;
                zero    <= (fix_result == '0);
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed-vector bench with behavioural model and per-cycle compare
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  alu_cnt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [31:0] rem_out;
    logic        cond;
    logic        zero;
    logic        div0;
    logic        illegal;
    logic        busy;
    logic        done;

    alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .alu_cnt (alu_cnt),
        .a       (a),
        .b       (b),
        .result  (result),
        .rem_out (rem_out),
        .cond    (cond),
        .zero    (zero),
        .div0    (div0),
        .illegal (illegal),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] rem;
        logic        cond;
        logic        zero;
        logic        div0;
        logic        ill;
        logic        multi;
    } exp_t;

    typedef struct {
        int   ac;
        int   dc;
        exp_t e;
    } rec_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    rec_t q[$];
    exp_t held;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    function automatic exp_t model(input logic [4:0] code, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint sx;
        longint sy;
        logic [4:0] sh;
        e  = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = y[4:0];
        case (code)
            5'd0:  e.res = x + y;
            5'd1:  e.res = x - y;
            5'd2:  e.res = ~x;
            5'd3:  e.res = x << sh;
            5'd4:  e.res = x >> sh;
            5'd5:  e.res = x & y;
            5'd6:  e.res = x | y;
            5'd7:  e.res = (sx < sy) ? 32'd1 : 32'd0;
            5'd8:  begin e.res = x - y; e.cond = (sx == sy); end
            5'd9:  begin e.res = x - y; e.cond = (sx != sy); end
            5'd10: begin e.res = x - y; e.cond = (sx >  sy); end
            5'd11: begin e.res = x - y; e.cond = (sx >= sy); end
            5'd12: begin e.res = x - y; e.cond = (sx <  sy); end
            5'd13: begin e.res = x - y; e.cond = (sx <= sy); end
            5'd14: begin e.res = y; e.cond = 1'b1; end
            5'd15: begin e.res = 32'(sx * sy); e.multi = 1'b1; end
            5'd16: begin
                if (y == 32'd0) begin
                    e.res  = 32'hFFFF_FFFF;
                    e.rem  = x;
                    e.div0 = 1'b1;
                end else begin
                    e.res   = 32'(sx / sy);
                    e.rem   = 32'(sx % sy);
                    e.multi = 1'b1;
                end
            end
            5'd17: e.res = 32'(sx >>> sh);
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // One compare per output on every cycle: held values change only at done,
    // flags clear at the accepting edge, busy spans accept..done.
    always @(negedge clk) begin
        logic exp_done;
        logic exp_busy;
        if (cyc > 0) begin
            exp_done = 1'b0;
            exp_busy = 1'b0;
            if (q.size() > 0) begin
                if (q[0].ac == cyc) begin
                    held.div0 = 1'b0;
                    held.ill  = 1'b0;
                end
                exp_busy = q[0].e.multi && (cyc >= q[0].ac) && (cyc < q[0].dc);
                if (q[0].dc == cyc) begin
                    exp_done = 1'b1;
                    held     = q[0].e;
                    void'(q.pop_front());
                end
            end
            chk("done",    {31'd0, done},    {31'd0, exp_done});
            chk("busy",    {31'd0, busy},    {31'd0, exp_busy});
            chk("result",  result,           held.res);
            chk("rem_out", rem_out,          held.rem);
            chk("cond",    {31'd0, cond},    {31'd0, held.cond});
            chk("zero",    {31'd0, zero},    {31'd0, held.zero});
            chk("div0",    {31'd0, div0},    {31'd0, held.div0});
            chk("illegal", {31'd0, illegal}, {31'd0, held.ill});
        end
    end

    task automatic issue(input logic [4:0] code, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] lit_res, input logic [31:0] lit_rem, input logic lit_cond,
                         input logic poke);
        rec_t r;
        r.e  = model(code, av, bv);
        r.ac = cyc + 1;
        r.dc = r.e.multi ? cyc + 34 : cyc + 1;
        chk("pin_res",  r.e.res, lit_res);
        chk("pin_rem",  r.e.rem, lit_rem);
        chk("pin_cond", {31'd0, r.e.cond}, {31'd0, lit_cond});
        q.push_back(r);
        start   = 1'b1;
        alu_cnt = code;
        a       = av;
        b       = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (poke) begin
            repeat (5) @(posedge clk);
            #1;
            start   = 1'b1;
            alu_cnt = 5'd0;
            a       = 32'd100;
            b       = 32'd200;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        for (int g = 0; g < 60 && cyc < r.dc; g++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rec_t r;
        held    = '0;
        rst     = 1'b1;
        start   = 1'b0;
        alu_cnt = 5'd0;
        a       = 32'd0;
        b       = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // imul aborted by reset partway through CALC
        r.e  = model(5'd15, 32'd5, 32'd9);
        r.ac = cyc + 1;
        r.dc = cyc + 34;
        q.push_back(r);
        start = 1'b1; alu_cnt = 5'd15; a = 32'd5; b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        held = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(5'd0,  32'd3,          32'd4,          32'd7,          32'd0, 1'b0, 1'b0);
        issue(5'd0,  32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  32'd0, 1'b0, 1'b0);
        issue(5'd1,  32'd5,          32'd5,          32'd0,          32'd0, 1'b0, 1'b0);
        issue(5'd2,  32'h0F0F_0000,  32'd0,          32'hF0F0_FFFF,  32'd0, 1'b0, 1'b0);
        issue(5'd5,  32'hFF00_FF00,  32'h0FF0_0FF0,  32'h0F00_0F00,  32'd0, 1'b0, 1'b0);
        issue(5'd6,  32'hFF00_0000,  32'h0000_00FF,  32'hFF00_00FF,  32'd0, 1'b0, 1'b0);
        issue(5'd17, 32'h8000_0000,  32'd4,          32'hF800_0000,  32'd0, 1'b0, 1'b0);
        issue(5'd4,  32'h8000_0000,  32'd4,          32'h0800_0000,  32'd0, 1'b0, 1'b0);
        issue(5'd3,  32'h8000_0000,  32'd4,          32'd0,          32'd0, 1'b0, 1'b0);
        issue(5'd7,  32'hFFFF_FFFF,  32'd1,          32'd1,          32'd0, 1'b0, 1'b0);
        issue(5'd12, 32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFB,  32'd0, 1'b1, 1'b0);
        issue(5'd11, 32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFB,  32'd0, 1'b0, 1'b0);
        issue(5'd13, 32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFB,  32'd0, 1'b1, 1'b0);
        issue(5'd9,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFB,  32'd0, 1'b1, 1'b0);
        issue(5'd10, 32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFB,  32'd0, 1'b0, 1'b0);
        issue(5'd8,  32'd6,          32'd6,          32'd0,          32'd0, 1'b1, 1'b0);
        issue(5'd14, 32'd123,        32'h40,         32'h40,         32'd0, 1'b1, 1'b0);
        issue(5'd15, 32'hFFFF_FFF9,  32'd6,          32'hFFFF_FFD6,  32'd0, 1'b0, 1'b1);
        issue(5'd16, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(5'd16, 32'd9,          32'd0,          32'hFFFF_FFFF,  32'd9, 1'b0, 1'b0);
        issue(5'd20, 32'd1,          32'd2,          32'd0,          32'd0, 1'b0, 1'b0);
        issue(5'd16, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0, 1'b0, 1'b0);
        issue(5'd16, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2, 1'b0, 1'b0);
        issue(5'd15, 32'h0001_0001,  32'h0001_0001,  32'h0002_0001,  32'd0, 1'b0, 1'b0);
        issue(5'd0,  32'd1,          32'd1,          32'd2,          32'd0, 1'b0, 1'b0);
        issue(5'd31, 32'd0,          32'd0,          32'd0,          32'd0, 1'b0, 1'b0);
        issue(5'd1,  32'd1,          32'd2,          32'hFFFF_FFFF,  32'd0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
